data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
// - Shares the single-port 8b x 256 data memory between NUM_REQ requesters. Requester 0 is the
//   core load/store stage; requester 1 is the test/program loader.
// - Round-robin arbitration with an optional per-requester lock for bursts.
// - One registered issue stage drives MemRead/MemWrite/DataAddress/DataMemIn.
// - Read data from DataMemOut is captured and returned with a per-requester valid strobe.
// PARAMETERS
// - NUM_REQ  2  number of requesters (2..4)
// - AW       8  address width
// - DW       8  data width
// PORTS
// - CLK         in   1           clock; all state changes on posedge
// - Reset       in   1           asynchronous, active-high reset
// - req         in   NUM_REQ     request; held stable until ack
// - we          in   NUM_REQ     1 = write, 0 = read; qualified by req
// - lock        in   NUM_REQ     keep the grant while req & lock stay high
// - addr        in   NUM_REQ*AW  per-requester address; slice i = [i*AW +: AW]
// - wdata       in   NUM_REQ*DW  per-requester write data
// - ack         out  NUM_REQ     one-hot combinational accept; the request is taken at this edge
// - rdata       out  DW          read data; shared bus, qualified by rvalid
// - rvalid      out  NUM_REQ     one-cycle strobe; rdata belongs to requester i
// - MemRead     out  1           to memory read enable
// - MemWrite    out  1           to memory write enable
// - DataAddress out  AW          to memory address
// - DataMemIn   out  DW          to memory write data
// - DataMemOut  in   DW          from memory; combinational read, Z when MemRead = 0
// BEHAVIOUR
// - Reset (async, immediate) clears:
//   - MemRead, MemWrite, DataAddress, DataMemIn, rdata, rvalid, and the issue register.
//   - last_grant is set to NUM_REQ-1, so requester 0 wins first.
//   - State goes to ARB_IDLE. ack is 0 while Reset is high.
// - Arbitration in cycle N:
//   - The winner is the first i with req[i] set, searching from last_grant+1 modulo NUM_REQ.
//   - ack[winner] = 1. Command {we, addr, wdata, id} loads into the issue register at the end of N.
//   - last_grant <= winner.
// - Issue in cycle N+1: the registered command drives memory.
//   - Write: MemWrite = 1; memory commits at the end of N+1.
//   - Read: MemRead = 1; DataMemOut is sampled into rdata at the end of N+1.
// - Return in cycle N+2: rvalid[id] = 1 for one cycle for reads; never for writes.
//   - Read latency is 2 cycles from the ack cycle.
// - Throughput is one command per cycle; back-to-back acks are allowed.
// - Read-after-write to the same address on consecutive acks returns the new data.
// - Memory enables are 0 in any cycle with no issued command.
// - DataAddress and DataMemIn hold their last values when idle.
// - FSM, evaluated each edge:
//   - ARB_IDLE: no command issued; goes to ARB_BUSY on any ack.
//   - ARB_BUSY: goes to ARB_LOCKED if the acked requester had lock = 1; goes to ARB_IDLE if there is no ack.
//   - ARB_LOCKED: only the lock owner may win.
//     - Owner req & lock both high -> stays ARB_LOCKED.
//     - Owner drops req or lock -> ARB_BUSY, or ARB_IDLE if nothing is acked; normal round-robin resumes.
// - Fairness: without lock, a requester with req held waits at most NUM_REQ-1 grants.
// - No ack ever goes to a requester with req = 0. ack is always one-hot or zero.
// - Reset mid-operation discards the in-flight command and its rvalid.
//   - A write in the issue cycle when Reset asserts is not guaranteed to commit.
// STRUCTURE
// - Package data_mem_arb_pkg holds:
//   - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_LOCKED}
//   - mem_cmd_t struct {we, addr[AW], wdata[DW], id}
//   - RESET_LAST_GRANT constant
// - Sub-module rr_arbiter: combinational rotate-priority pick.
//   - Inputs: req, last_grant, lock_owner, lock_en. Outputs: one-hot grant, grant index.
// TESTING
// - Single read: after Reset, req0 rd addr 8'h10 (mem = 8'hA5).
//   -> ack0 in cycle 0, MemRead in cycle 1, rvalid0 in cycle 2 with rdata = 8'hA5.
// - Write then read: req1 wr 8'h20 <= 8'h3C, then req1 rd 8'h20 on the next cycle.
//   -> rvalid1 with rdata = 8'h3C, 2 cycles after the second ack.
// - Contention: req0 and req1 both held continuously.
//   -> acks alternate 0, 1, 0, 1; first ack goes to 0 after reset.
// - Lock burst: req1 + lock1 for 4 writes while req0 is held.
//   -> 4 consecutive ack1; ack0 on the cycle after lock1 drops.
// - Idle and write: with no req, MemRead = MemWrite = 0; a write never produces rvalid.
// - Reset mid-read: Reset asserted in the issue cycle.
//   -> rvalid stays 0, all outputs are 0, and the next req0 gets ack0 as the first grant.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

  localparam int unsigned MEM_AW          = 8;
  localparam int unsigned MEM_DW          = 8;
  localparam int unsigned ID_W            = 2;  // covers up to 4 requesters
  localparam int unsigned DEFAULT_NUM_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
    logic [ID_W-1:0]   id;
  } mem_cmd_t;

  // Highest index is "last granted" out of reset so requester 0 wins first.
  function automatic logic [ID_W-1:0] reset_last_grant(input int unsigned num_req);
    return ID_W'(num_req - 1);
  endfunction

  localparam logic [ID_W-1:0] RESET_LAST_GRANT = reset_last_grant(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick; with lock_en only the lock owner can win.
module rr_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  input  logic [ID_W-1:0]    lock_owner_i,
  input  logic               lock_en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    if (lock_en_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (lock_owner_i == ID_W'(i) && req_i[i]) begin
          grant_o[i]  = 1'b1;
          grant_idx_o = ID_W'(i);
        end
      end
    end else begin
      // Search starts one past the last winner and wraps.
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!found && req_i[i] && ((32'(last_grant_i) + off) % NUM_REQ) == i) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = ID_W'(i);
            found       = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port data memory;
// one registered issue stage, read data returned two cycles after ack.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned AW      = MEM_AW,
  parameter int unsigned DW      = MEM_DW
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [AW-1:0]         DataAddress,
  output logic [DW-1:0]         DataMemIn,
  input  logic [DW-1:0]         DataMemOut
);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic                cmd_valid_q;
  logic [DW-1:0]       rdata_q;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                owner_holds, lock_en, any_ack, acked_lock;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_owner_i (last_grant_q),
    .lock_en_i    (lock_en),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // In ARB_LOCKED the owner is always the last winner.
  always_comb begin
    owner_holds = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (last_grant_q == ID_W'(i)) owner_holds = req[i] & lock[i];
    end
    lock_en = (state_q == ARB_LOCKED) && owner_holds;
  end

  assign ack        = Reset ? '0 : grant;
  assign any_ack    = |ack;
  assign acked_lock = |(ack & lock);

  always_comb begin
    state_d      = state_q;
    last_grant_d = any_ack ? grant_idx : last_grant_q;
    unique case (state_q)
      ARB_IDLE:   if (any_ack) state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (!any_ack)        state_d = ARB_IDLE;
        else if (acked_lock) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (owner_holds)     state_d = ARB_LOCKED;
        else if (any_ack)    state_d = ARB_BUSY;
        else                 state_d = ARB_IDLE;
      end
      default:               state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cmd_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cmd_d.we    = we[i];
        cmd_d.addr  = addr[i*AW +: AW];
        cmd_d.wdata = wdata[i*DW +: DW];
        cmd_d.id    = ID_W'(i);
      end
    end
  end

  assign MemRead     = cmd_valid_q & ~cmd_q.we;
  assign MemWrite    = cmd_valid_q & cmd_q.we;
  assign DataAddress = cmd_q.addr;
  assign DataMemIn   = cmd_q.wdata;
  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;

  always_comb begin
    rvalid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = MemRead && (cmd_q.id == ID_W'(i));
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= reset_last_grant(NUM_REQ);
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= any_ack;
      if (any_ack) cmd_q <= cmd_d;
      if (MemRead) rdata_q <= DataMemOut;
      rvalid_q     <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed cycle-table bench for data_mem_arbiter with a behavioural 256x8 memory.
module tb_data_mem_arbiter;

  logic        clk, rst;
  logic [1:0]  req, we, lock;
  logic [15:0] addr, wdata;
  logic [1:0]  ack, rvalid;
  logic [7:0]  rdata, daddr, din;
  logic        mrd, mwr;
  wire  [7:0]  dout;

  logic [7:0]  mem [256];
  logic        preload;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(
    .NUM_REQ (2),
    .AW      (8),
    .DW      (8)
  ) dut (
    .CLK         (clk),
    .Reset       (rst),
    .req         (req),
    .we          (we),
    .lock        (lock),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .MemRead     (mrd),
    .MemWrite    (mwr),
    .DataAddress (daddr),
    .DataMemIn   (din),
    .DataMemOut  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) mem[8'h10] <= 8'hA5;
    else if (mwr) mem[daddr] <= din;
  end
  assign dout = mrd ? mem[daddr] : 8'hzz;

  typedef struct {
    logic [1:0] req, we, lock;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] ack;
    logic       rd, wr;
    logic [1:0] rv;
    logic [7:0] rdata;
  } vec_t;

  function automatic vec_t v(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                             input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [1:0] ak, input logic rd, input logic wr,
                             input logic [1:0] rv, input logic [7:0] rdt);
    vec_t r;
    r.req = rq; r.we = w; r.lock = lk;
    r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.ack = ak; r.rd = rd; r.wr = wr; r.rv = rv; r.rdata = rdt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    // Each row is one cycle: inputs driven, then outputs seen in that same cycle.
    vecs[0]  = v(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 0, 0, 2'b00, 8'h00);
    vecs[1]  = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1, 0, 2'b00, 8'h00);
    vecs[2]  = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b01, 8'hA5);
    vecs[3]  = v(2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h3C, 2'b10, 0, 0, 2'b00, 8'h00);
    vecs[4]  = v(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10, 0, 1, 2'b00, 8'h00);
    vecs[5]  = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1, 0, 2'b00, 8'h00);
    vecs[6]  = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b10, 8'h3C);
    vecs[7]  = v(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 0, 0, 2'b00, 8'h00);
    vecs[8]  = v(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 1, 0, 2'b00, 8'h00);
    vecs[9]  = v(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 1, 0, 2'b01, 8'hA5);
    vecs[10] = v(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 1, 0, 2'b10, 8'h3C);
    vecs[11] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1, 0, 2'b01, 8'hA5);
    vecs[12] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b10, 8'h3C);
    vecs[13] = v(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 0, 0, 2'b00, 8'h00);
    vecs[14] = v(2'b11, 2'b10, 2'b10, 8'h10, 8'h30, 8'h00, 8'h11, 2'b10, 1, 0, 2'b00, 8'h00);
    vecs[15] = v(2'b11, 2'b10, 2'b10, 8'h10, 8'h31, 8'h00, 8'h22, 2'b10, 0, 1, 2'b01, 8'hA5);
    vecs[16] = v(2'b11, 2'b10, 2'b10, 8'h10, 8'h32, 8'h00, 8'h33, 2'b10, 0, 1, 2'b00, 8'h00);
    vecs[17] = v(2'b11, 2'b10, 2'b10, 8'h10, 8'h33, 8'h00, 8'h44, 2'b10, 0, 1, 2'b00, 8'h00);
    vecs[18] = v(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 0, 1, 2'b00, 8'h00);
    vecs[19] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1, 0, 2'b00, 8'h00);
    vecs[20] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b01, 8'hA5);
    vecs[21] = v(2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'h5A, 8'h00, 2'b01, 0, 0, 2'b00, 8'h00);
    vecs[22] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 1, 2'b00, 8'h00);
    vecs[23] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 8'h00);
    vecs[24] = v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 2'b00, 8'h00);

    rst = 1'b1; preload = 1'b1;
    req = 2'b11; we = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_memread", 32'(mrd), 32'h0);
    chk("reset_memwrite", 32'(mwr), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_daddr", 32'(daddr), 32'h0);
    chk("reset_din", 32'(din), 32'h0);
    rst = 1'b0; preload = 1'b0; req = 2'b00;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      req   = vecs[k].req;
      we    = vecs[k].we;
      lock  = vecs[k].lock;
      addr  = {vecs[k].a1, vecs[k].a0};
      wdata = {vecs[k].d1, vecs[k].d0};
      #3;
      chk($sformatf("row%0d_ack", k), 32'(ack), 32'(vecs[k].ack));
      chk($sformatf("row%0d_memread", k), 32'(mrd), 32'(vecs[k].rd));
      chk($sformatf("row%0d_memwrite", k), 32'(mwr), 32'(vecs[k].wr));
      chk($sformatf("row%0d_rvalid", k), 32'(rvalid), 32'(vecs[k].rv));
      if (vecs[k].rv != 2'b00)
        chk($sformatf("row%0d_rdata", k), 32'(rdata), 32'(vecs[k].rdata));
    end

    // Idle: address/data hold the last issued write; memory holds all writes.
    chk("idle_hold_daddr", 32'(daddr), 32'h40);
    chk("idle_hold_din", 32'(din), 32'h5A);
    chk("mem_20", 32'(mem[8'h20]), 32'h3C);
    chk("mem_30", 32'(mem[8'h30]), 32'h11);
    chk("mem_31", 32'(mem[8'h31]), 32'h22);
    chk("mem_32", 32'(mem[8'h32]), 32'h33);
    chk("mem_33", 32'(mem[8'h33]), 32'h44);
    chk("mem_40", 32'(mem[8'h40]), 32'h5A);

    // Reset asserted in the issue cycle of a read.
    @(posedge clk); #1;
    req = 2'b01; we = 2'b00; lock = 2'b00; addr = {8'h20, 8'h10};
    #3;
    chk("rst_mid_ack", 32'(ack), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    chk("rst_mid_ack_held", 32'(ack), 32'h0);
    chk("rst_mid_memread", 32'(mrd), 32'h0);
    chk("rst_mid_memwrite", 32'(mwr), 32'h0);
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid_daddr", 32'(daddr), 32'h0);
    chk("rst_mid_din", 32'(din), 32'h0);
    chk("rst_mid_rdata", 32'(rdata), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_rvalid2", 32'(rvalid), 32'h0);
    rst = 1'b0; req = 2'b11;
    #3;
    chk("post_rst_first_ack", 32'(ack), 32'h1);
    chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    req = 2'b00;
    #3;
    chk("post_rst_memread", 32'(mrd), 32'h1);
    chk("post_rst_daddr", 32'(daddr), 32'h10);
    @(posedge clk); #1; #3;
    chk("post_rst_rvalid0", 32'(rvalid), 32'h1);
    chk("post_rst_rdata", 32'(rdata), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
